asp_irq_ctrl: RTL
=================

Name: asp_irq_ctrl

Overview:
MMIO-visible interrupt responder for the ASP. Latches rising edges from the ASP interrupt sources (DMA_0 = bit 0, kernel = bit 1, DMA_1 = bit 2) into a status register and gates them with a host-programmed mask. Issues one interrupt message per pending event to the host-channel interrupt port through a valid/ready handshake. Sits between the board-level IRQ sources and the MMIO64 AVMM slave tree.

Parameters:
NUM_IRQ, 3, number of interrupt sources used (bit index = source id)
NUM_LINES, 4, host interrupt vectors available; requires NUM_IRQ <= NUM_LINES
ADDR_WIDTH, 18, MMIO64 AVMM byte-address width
DATA_WIDTH, 64, AVMM data width
CNT_WIDTH, 16, per-source event counter width

Ports:
clk  in  1  single clock domain
reset  in  1  asynchronous, active-high
irq_in  in  NUM_IRQ  level interrupt sources
avmm_address  in  ADDR_WIDTH  byte address; bits [5:3] select the register
avmm_read  in  1  read request
avmm_write  in  1  write request
avmm_writedata  in  DATA_WIDTH  write data
avmm_byteenable  in  DATA_WIDTH/8  byte enables
avmm_waitrequest  out  1  stall
avmm_readdata  out  DATA_WIDTH  read data
avmm_readdatavalid  out  1  read response strobe
irq_valid  out  1  interrupt message valid
irq_vector  out  $clog2(NUM_LINES)  interrupt vector (= source index)
irq_ready  in  1  host accepts the message

Behaviour:
- Reset values: avmm_waitrequest=1 while reset is asserted, 0 from the first clk edge after deassertion. avmm_readdata=0, avmm_readdatavalid=0, irq_valid=0, irq_vector=0. STATUS, MASK, SENT, counters and the irq_in sample register all 0.
- Edge detect: irq_in is registered each cycle. A 0->1 transition sets STATUS[i] on the next edge, i.e. 1 cycle after irq_in rises. A level held high does not re-set STATUS after it is cleared; only a new rising edge does.
- Counters: CNT[i] increments on each detected edge and saturates at all-ones.
- Register map (word offsets; DATA_WIDTH=64):
  - 0x00 ID: RO constant 0x0000_4952_5143_0001.
  - 0x08 STATUS: RO, bits [NUM_IRQ-1:0].
  - 0x10 MASK: RW; 1 = enabled.
  - 0x18 CLEAR: WO, write-1-to-clear STATUS and SENT; reads return 0.
  - 0x20 COUNT: RO; CNT[i] at bits [i*CNT_WIDTH +: CNT_WIDTH]. Any write clears all counters.
  - Other offsets: reads return 0, writes are ignored.
- Writes take effect only when avmm_byteenable[0]=1 (MASK/CLEAR); COUNT clear ignores byteenable.
- Simultaneous set and clear of the same STATUS bit: set wins, STATUS stays 1 and SENT is cleared, so the interrupt is re-issued. Simultaneous edge and counter clear: counter ends at 1.
- Read latency is fixed at 1: avmm_readdatavalid pulses for one cycle the clk after a read is accepted. Reads are pipelined back-to-back with no stall. A read and write in the same cycle is illegal and not checked.
- Interrupt FSM:
  - IDLE: compute pend = STATUS & MASK & ~SENT. If nonzero, latch irq_vector = lowest set index and go to SEND.
  - SEND: irq_valid=1, irq_vector held stable until irq_ready. On irq_valid&irq_ready set SENT[vector] and go to IDLE; irq_valid drops the next cycle, giving a 1-cycle minimum gap.
  - A clear of STATUS[vector] during SEND does not retract the message; valid stays until accepted.
  - Masking during SEND does not retract either.
- Exactly one message per STATUS set/clear cycle per source. Re-arming requires a CLEAR write.
- reset asserted mid-operation immediately drops irq_valid and avmm_readdatavalid and clears all state, including a pending SEND.

Test Plan:
- Reset release -> waitrequest 1->0; read 0x00 returns 0x0000_4952_5143_0001 with readdatavalid exactly 1 cycle later; read 0x08 = 0.
- MASK=0x7, pulse irq_in[1] -> STATUS=0x2 one cycle later; irq_valid=1, vector=1; hold irq_ready=0 for 5 cycles -> vector stable; ready=1 -> single message, no repeat while STATUS[1]=1.
- MASK=0, irq_in rises on bits 0 and 2 together -> STATUS=0x5, no irq_valid; write MASK=0x7 -> messages vector 0 then vector 2, with >=1 idle cycle between.
- CLEAR write 0x2 in the same cycle as a new irq_in[1] edge -> STATUS[1] stays 1 and a second message with vector 1 is issued.
- Pulse irq_in[0] 0x10005 times -> COUNT[15:0]=0xFFFF (saturated); write 0x20 -> reads 0.
- Assert reset during SEND with irq_ready=0 -> irq_valid=0 immediately; after release STATUS=0 and no message.

Source files
------------

// File: rtl/asp_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// asp_irq_ctrl_if
//   Bus bundle for the ASP interrupt responder: the MMIO64 AVMM slave port
//   plus the valid/ready interrupt-message port toward the host channel.
//
//   master modport : host side (drives AVMM requests, accepts irq messages)
//   slave modport  : asp_irq_ctrl side (answers AVMM, issues irq messages)
// ---------------------------------------------------------------------------
interface asp_irq_ctrl_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 64,
    parameter int VEC_WIDTH  = 2
);
    logic [ADDR_WIDTH-1:0]   avmm_address;
    logic                    avmm_read;
    logic                    avmm_write;
    logic [DATA_WIDTH-1:0]   avmm_writedata;
    logic [DATA_WIDTH/8-1:0] avmm_byteenable;
    logic                    avmm_waitrequest;
    logic [DATA_WIDTH-1:0]   avmm_readdata;
    logic                    avmm_readdatavalid;
    logic                    irq_valid;
    logic [VEC_WIDTH-1:0]    irq_vector;
    logic                    irq_ready;

    modport master (
        output avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
        input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
        input  irq_valid, irq_vector,
        output irq_ready
    );

    modport slave (
        input  avmm_address, avmm_read, avmm_write, avmm_writedata, avmm_byteenable,
        output avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
        output irq_valid, irq_vector,
        input  irq_ready
    );
endinterface

// File: rtl/asp_irq_ctrl.sv
// ---------------------------------------------------------------------------
// asp_irq_ctrl
//   MMIO-visible interrupt responder. Rising edges on irq_in are latched into
//   STATUS, gated by MASK, and each pending event produces exactly one
//   interrupt message (vector = source index) on the valid/ready port.
//   SENT remembers which sources were already reported; a CLEAR write re-arms.
//
//   clk    : single clock
//   reset  : asynchronous, active-high
//   irq_in : level interrupt sources (bit index = source id)
//   bus    : AVMM slave + interrupt-message port (asp_irq_ctrl_if.slave)
//
//   Register map (address bits [5:3]):
//     0 ID (RO)  1 STATUS (RO)  2 MASK (RW)  3 CLEAR (WO, W1C)  4 COUNT (RO,
//     any write clears)  5..7 read 0 / write ignored
// ---------------------------------------------------------------------------
module asp_irq_ctrl #(
    parameter int NUM_IRQ    = 3,
    parameter int NUM_LINES  = 4,
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    asp_irq_ctrl_if.slave      bus
);
    localparam int VEC_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [63:0] ID_VALUE = 64'h0000_4952_5143_0001;

    localparam logic [2:0] REG_ID     = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_MASK   = 3'd2;
    localparam logic [2:0] REG_CLEAR  = 3'd3;
    localparam logic [2:0] REG_COUNT  = 3'd4;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    logic [NUM_IRQ-1:0]           irq_in_q, irq_in_d;
    logic [NUM_IRQ-1:0]           status_q, status_d;
    logic [NUM_IRQ-1:0]           mask_q, mask_d;
    logic [NUM_IRQ-1:0]           sent_q, sent_d;
    logic                         waitreq_q;
    logic [DATA_WIDTH-1:0]        readdata_q, readdata_d;
    logic                         rdvalid_q, rdvalid_d;
    state_t                       state_q, state_d;
    logic [VEC_W-1:0]             vector_q, vector_d;

    logic                         rd_acc, wr_acc;
    logic [2:0]                   reg_sel;
    logic [NUM_IRQ-1:0]           rise, clr_bits, acc_bits, pend;
    logic                         cnt_clr, accept;
    logic [VEC_W-1:0]             pend_idx;
    logic [NUM_IRQ*CNT_WIDTH-1:0] cnt_flat;
    logic [DATA_WIDTH-1:0]        rdata_mux;
    logic                         unused_bus_bits;

    // Requests are only taken once waitrequest has dropped after reset.
    assign rd_acc  = bus.avmm_read  & ~waitreq_q;
    assign wr_acc  = bus.avmm_write & ~waitreq_q;
    assign reg_sel = bus.avmm_address[5:3];

    assign rise     = irq_in & ~irq_in_q;
    assign clr_bits = (wr_acc && reg_sel == REG_CLEAR && bus.avmm_byteenable[0])
                      ? bus.avmm_writedata[NUM_IRQ-1:0] : '0;
    assign cnt_clr  = wr_acc && (reg_sel == REG_COUNT);
    assign accept   = (state_q == ST_SEND) && bus.irq_ready;
    assign pend     = status_q & mask_q & ~sent_q;

    assign unused_bus_bits = ^{bus.avmm_address[ADDR_WIDTH-1:6], bus.avmm_address[2:0],
                               bus.avmm_writedata[DATA_WIDTH-1:NUM_IRQ],
                               bus.avmm_byteenable[DATA_WIDTH/8-1:1]};

    // Per-source saturating event counters; a clear and an edge in the same
    // cycle leave the counter at 1.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_clr ? '0 : cnt_q;
                if (rise[gi] && (cnt_d != '1)) begin
                    cnt_d = cnt_d + CNT_WIDTH'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        end
    endgenerate

    // One-hot of the vector being accepted this cycle.
    always_comb begin
        acc_bits = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            acc_bits[i] = accept && (vector_q == VEC_W'(i));
        end
    end

    // Register file next state. A fresh edge wins over a clear of the same
    // STATUS bit, while the clear still drops SENT so the source re-fires.
    // Clear also wins over an acceptance so a cleared source is never left
    // with a stale SENT bit.
    always_comb begin
        irq_in_d = irq_in;
        status_d = (status_q & ~clr_bits) | rise;
        sent_d   = (sent_q | acc_bits) & ~clr_bits;
        mask_d   = mask_q;
        if (wr_acc && reg_sel == REG_MASK && bus.avmm_byteenable[0]) begin
            mask_d = bus.avmm_writedata[NUM_IRQ-1:0];
        end
    end

    // Read mux, registered for a fixed one-cycle latency.
    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            REG_ID:     rdata_mux = DATA_WIDTH'(ID_VALUE);
            REG_STATUS: rdata_mux = DATA_WIDTH'(status_q);
            REG_MASK:   rdata_mux = DATA_WIDTH'(mask_q);
            REG_COUNT:  rdata_mux = DATA_WIDTH'(cnt_flat);
            default:    rdata_mux = '0;
        endcase
        readdata_d = rd_acc ? rdata_mux : readdata_q;
        rdvalid_d  = rd_acc;
    end

    // Lowest pending source index.
    always_comb begin
        pend_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) pend_idx = VEC_W'(i);
        end
    end

    // Interrupt FSM: next-state process.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        case (state_q)
            ST_IDLE: begin
                if (|pend) begin
                    state_d  = ST_SEND;
                    vector_d = pend_idx;
                end
            end
            ST_SEND: begin
                // Held until accepted even if STATUS is cleared or masked.
                if (bus.irq_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Interrupt FSM: output process.
    always_comb begin
        bus.irq_valid  = (state_q == ST_SEND);
        bus.irq_vector = vector_q;
    end

    assign bus.avmm_waitrequest   = waitreq_q;
    assign bus.avmm_readdata      = readdata_q;
    assign bus.avmm_readdatavalid = rdvalid_q;

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_in_q   <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            sent_q     <= '0;
            waitreq_q  <= 1'b1;
            readdata_q <= '0;
            rdvalid_q  <= 1'b0;
            state_q    <= ST_IDLE;
            vector_q   <= '0;
        end else begin
            irq_in_q   <= irq_in_d;
            status_q   <= status_d;
            mask_q     <= mask_d;
            sent_q     <= sent_d;
            waitreq_q  <= 1'b0;
            readdata_q <= readdata_d;
            rdvalid_q  <= rdvalid_d;
            state_q    <= state_d;
            vector_q   <= vector_d;
        end
    end
endmodule
